// File: rtl/node_snapshot_streamer.sv
// Captures all node positions on snap_req and streams them out one node per beat.
// Optional SNAPSHOT_CHECKSUM_EN adds out_checksum, the XOR of every captured x and y word.
module node_snapshot_streamer #(
  parameter int unsigned NODE_COUNT = 5,
  parameter int unsigned CORE_ID    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    snap_req,
  input  logic [32*NODE_COUNT-1:0] x_flat,
  input  logic [32*NODE_COUNT-1:0] y_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_node_idx,
  output logic [31:0]             out_x,
  output logic [31:0]             out_y,
  output logic                    out_last,
  output logic [15:0]             out_frame,
  output logic [7:0]              out_core_id,
  output logic                    busy,
  output logic                    overrun
`ifdef SNAPSHOT_CHECKSUM_EN
  ,
  output logic [31:0]             out_checksum
`endif
);

  localparam logic [7:0] LastIdx = 8'(NODE_COUNT - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e      state_q;
  logic [31:0] snap_x_q [NODE_COUNT];
  logic [31:0] snap_y_q [NODE_COUNT];

  logic        beat_done;
  logic        last_done;
  logic        capture;
  logic [7:0]  next_idx;
  logic [31:0] next_x;
  logic [31:0] next_y;

  assign beat_done   = out_valid && out_ready;
  assign last_done   = beat_done && out_last;
  // A request is honoured when idle, or exactly on the final handshake (back-to-back frame).
  assign capture     = snap_req && ((state_q == StIdle) || last_done);
  assign next_idx    = out_node_idx + 8'd1;
  assign busy        = (state_q == StStream);
  assign out_core_id = 8'(CORE_ID);

  // Decoded mux avoids indexing the snapshot array with a wider-than-needed index.
  always_comb begin
    next_x = '0;
    next_y = '0;
    for (int i = 0; i < NODE_COUNT; i++) begin
      if (next_idx == 8'(i)) begin
        next_x = snap_x_q[i];
        next_y = snap_y_q[i];
      end
    end
  end

`ifdef SNAPSHOT_CHECKSUM_EN
  logic [31:0] checksum_d;

  always_comb begin
    checksum_d = '0;
    for (int i = 0; i < NODE_COUNT; i++) begin
      checksum_d = checksum_d ^ x_flat[32*i +: 32] ^ y_flat[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_checksum <= '0;
    end else if (capture) begin
      out_checksum <= checksum_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_node_idx <= '0;
      out_x        <= '0;
      out_y        <= '0;
      out_frame    <= '0;
      overrun      <= 1'b0;
      for (int i = 0; i < NODE_COUNT; i++) begin
        snap_x_q[i] <= '0;
        snap_y_q[i] <= '0;
      end
    end else begin
      if (capture) begin
        for (int i = 0; i < NODE_COUNT; i++) begin
          snap_x_q[i] <= x_flat[32*i +: 32];
          snap_y_q[i] <= y_flat[32*i +: 32];
        end
        // Node 0 comes straight from the inputs so it is visible the cycle after the request.
        state_q      <= StStream;
        out_valid    <= 1'b1;
        out_node_idx <= '0;
        out_x        <= x_flat[31:0];
        out_y        <= y_flat[31:0];
        out_last     <= 1'b0;
        out_frame    <= out_frame + 16'd1;
      end else if ((state_q == StStream) && beat_done) begin
        if (out_last) begin
          state_q   <= StIdle;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          out_node_idx <= next_idx;
          out_x        <= next_x;
          out_y        <= next_y;
          out_last     <= (next_idx == LastIdx);
        end
      end

      if ((state_q == StStream) && snap_req && !last_done) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_node_snapshot_streamer.sv
// Directed bench for node_snapshot_streamer: streaming, stalls, overrun, back-to-back and reset abort.
module tb_node_snapshot_streamer;

  localparam int unsigned N = 5;

  logic             clk;
  logic             reset;
  logic             snap_req;
  logic [32*N-1:0]  x_flat;
  logic [32*N-1:0]  y_flat;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_node_idx;
  logic [31:0]      out_x;
  logic [31:0]      out_y;
  logic             out_last;
  logic [15:0]      out_frame;
  logic [7:0]       out_core_id;
  logic             busy;
  logic             overrun;

  int vectors = 0;
  int errors  = 0;

  node_snapshot_streamer #(
    .NODE_COUNT (N),
    .CORE_ID    (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .snap_req     (snap_req),
    .x_flat       (x_flat),
    .y_flat       (y_flat),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_node_idx (out_node_idx),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_last     (out_last),
    .out_frame    (out_frame),
    .out_core_id  (out_core_id),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Advance one edge; sampling and driving both happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [31:0] bx, input logic [31:0] by);
    for (int i = 0; i < N; i++) begin
      x_flat[32*i +: 32] = bx + 32'(i);
      y_flat[32*i +: 32] = by + 32'(i);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [31:0] bx,
                            input logic [31:0] by);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_idx"}, 32'(out_node_idx), 32'(idx));
    check({tag, "_x"}, out_x, bx + 32'(idx));
    check({tag, "_y"}, out_y, by + 32'(idx));
    check({tag, "_last"}, 32'(out_last), (idx == N - 1) ? 32'd1 : 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    snap_req  = 1'b0;
    out_ready = 1'b1;
    set_data(32'h100, 32'h200);
    #1;
    do_reset();

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame", 32'(out_frame), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_x", out_x, 32'd0);
    check("rst_y", out_y, 32'd0);
    check("rst_idx", 32'(out_node_idx), 32'd0);
    check("core_id", 32'(out_core_id), 32'd1);

    // Basic frame: five consecutive beats, node 0 the cycle after the request
    pulse_snap();
    check("b_frame", 32'(out_frame), 32'd1);
    check("b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < N; i++) begin
      check_beat("basic", i, 32'h100, 32'h200);
      step();
    end
    check("b_end_valid", 32'(out_valid), 32'd0);
    check("b_end_busy", 32'(busy), 32'd0);
    check("b_end_last", 32'(out_last), 32'd0);
    check("b_end_frame", 32'(out_frame), 32'd1);
    check("b_hold_idx", 32'(out_node_idx), 32'd4);
    check("b_hold_x", out_x, 32'h104);
    step();
    check("b_idle_valid", 32'(out_valid), 32'd0);

    // Stall on beat 2 and live input change after capture
    pulse_snap();
    step();
    step();
    check_beat("pre_stall", 2, 32'h100, 32'h200);
    out_ready = 1'b0;
    x_flat[32*3 +: 32] = 32'hDEAD_BEEF;
    y_flat[32*3 +: 32] = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      step();
      check_beat("stall", 2, 32'h100, 32'h200);
    end
    out_ready = 1'b1;
    step();
    check_beat("post_stall", 3, 32'h100, 32'h200);
    step();
    check_beat("post_stall", 4, 32'h100, 32'h200);
    step();
    check("s_end_valid", 32'(out_valid), 32'd0);
    check("s_frame", 32'(out_frame), 32'd2);
    set_data(32'h100, 32'h200);

    // Overrun: request during beat 1 is dropped, frame still ends after node 4
    do_reset();
    pulse_snap();
    step();
    check_beat("ovr", 1, 32'h100, 32'h200);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    check("ovr_flag", 32'(overrun), 32'd1);
    check_beat("ovr", 2, 32'h100, 32'h200);
    step();
    step();
    check_beat("ovr", 4, 32'h100, 32'h200);
    step();
    check("ovr_end_valid", 32'(out_valid), 32'd0);
    check("ovr_frame", 32'(out_frame), 32'd1);
    step();
    step();
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Back-to-back: request on the last handshake recaptures with no bubble
    do_reset();
    pulse_snap();
    for (int i = 0; i < N - 1; i++) step();
    check_beat("b2b_first", 4, 32'h100, 32'h200);
    set_data(32'h300, 32'h400);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    check_beat("b2b_second", 0, 32'h300, 32'h400);
    check("b2b_frame", 32'(out_frame), 32'd2);
    check("b2b_overrun", 32'(overrun), 32'd0);
    step();
    check_beat("b2b_second", 1, 32'h300, 32'h400);

    // Reset mid-stream aborts the frame; snap_req ignored while reset is high
    do_reset();
    set_data(32'h100, 32'h200);
    pulse_snap();
    step();
    step();
    check_beat("abort_pre", 2, 32'h100, 32'h200);
    reset    = 1'b1;
    snap_req = 1'b1;
    step();
    reset    = 1'b0;
    snap_req = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_frame", 32'(out_frame), 32'd0);
    check("abort_overrun", 32'(overrun), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_x", out_x, 32'd0);
    step();
    check("abort_stay_idle", 32'(out_valid), 32'd0);
    set_data(32'h500, 32'h600);
    pulse_snap();
    check_beat("restart", 0, 32'h500, 32'h600);
    check("restart_frame", 32'(out_frame), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
